multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Moore-style control FSM for the multicycle RV32I datapath. It sits directly upstream of the memory system. It drives the memory write enable and the address-source select (PC vs. ALUOut), which feeds the memory system's address input. It also sequences instruction-register capture, register-file writes and ALU operand/operation selects for every instruction. It counts retired instructions and flags unsupported opcodes.

## Interface
- COUNT_WIDTH, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Opcode_i  in  7  instruction[6:0] from instruction register
- Funct3_i  in  3  instruction[14:12]
- Zero_i  in  1  ALU zero flag (combinational, valid in BRANCH)
- PC_Write_o  out  1  load PC
- IR_Write_o  out  1  load instruction register and OldPC
- Adr_Src_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- Mem_Write_o  out  1  memory system write enable
- Reg_Write_o  out  1  register-file write enable
- ALU_Src_A_o  out  2  00 PC, 01 OldPC, 10 RegA
- ALU_Src_B_o  out  2  00 RegB, 01 Imm, 10 constant 4
- ALU_Op_o  out  2  00 add, 01 subtract, 10 decode funct
- Result_Src_o  out  2  00 ALUOut, 01 read data, 10 ALU result
- State_o  out  4  current state encoding (debug)
- Illegal_o  out  1  sticky: unsupported opcode decoded
- Instr_Count_o  out  COUNT_WIDTH  retired-instruction count

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - EXEC_R = 6, EXEC_I = 7, ALU_WB = 8, BRANCH = 9, JAL = 10
  - Encodings 11–15 are unreachable; if entered, next state = FETCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE by opcode: 0000011/0100011 → MEM_ADDR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; 1101111 → JAL; any other opcode → FETCH with Illegal_o set.
  - MEM_ADDR → MEM_READ if opcode = 0000011, else MEM_WRITE.
  - MEM_READ → MEM_WB.
  - EXEC_R, EXEC_I and JAL → ALU_WB.
  - MEM_WB, MEM_WRITE, ALU_WB and BRANCH → FETCH.
- Outputs are combinational from the state register. Any output not listed for a state is 0.
  - FETCH: IR_Write = 1, PC_Write = 1, Adr_Src = 0, SrcA = 00, SrcB = 10, Op = 00, Result = 10.
  - DECODE: SrcA = 01, SrcB = 01, Op = 00 (precomputes branch/jump target).
  - MEM_ADDR: SrcA = 10, SrcB = 01, Op = 00.
  - MEM_READ: Adr_Src = 1, Result = 00.
  - MEM_WB: Reg_Write = 1, Result = 01.
  - MEM_WRITE: Adr_Src = 1, Mem_Write = 1, Result = 00.
  - EXEC_R: SrcA = 10, SrcB = 00, Op = 10.
  - EXEC_I: SrcA = 10, SrcB = 01, Op = 10.
  - ALU_WB: Reg_Write = 1, Result = 00.
  - BRANCH: SrcA = 10, SrcB = 00, Op = 01, Result = 00, PC_Write = branch taken.
  - JAL: SrcA = 01, SrcB = 10, Op = 00, Result = 00, PC_Write = 1.
- Branch taken (the only Mealy term):
  - Funct3 = 000 (beq): taken when Zero_i = 1.
  - Funct3 = 001 (bne): taken when Zero_i = 0.
  - Any other Funct3: not taken.
- Instr_Count_o increments by 1 on every clock edge leaving MEM_WB, MEM_WRITE, ALU_WB or BRANCH. It wraps modulo 2^COUNT_WIDTH. Illegal opcodes do not count.
- Illegal_o is set on the DECODE → FETCH illegal transition and is cleared only by reset.

## Timing
- Reset (reset = 0, asynchronous):
  - State = FETCH, Instr_Count_o = 0, Illegal_o = 0.
  - While reset is held, outputs show the FETCH decode: PC_Write = 1, IR_Write = 1, Mem_Write = 0, Reg_Write = 0. Datapath registers share the reset, so this is harmless.
- Reset released mid-instruction: the FSM restarts at FETCH; no partial write completes after reset asserts.
- Cycles per instruction:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - beq/bne: 3
  - illegal opcode: 2
- Mem_Write_o is high for exactly one cycle per sw. Reg_Write_o is high for exactly one cycle per lw/R/I/jal.
- Instr_Count_o updates on the same edge that enters FETCH.
- Opcode_i and Funct3_i are sampled in DECODE and MEM_ADDR/BRANCH. The instruction register must hold them stable after FETCH.

## Test plan
- Reset → after release, State_o = 0, Instr_Count_o = 0, Illegal_o = 0, Mem_Write_o = 0; with Opcode = 0110011, State_o sequence is 0, 1, 6, 8, 0 and Instr_Count_o = 1.
- lw (0000011) then sw (0100011) → states 0-1-2-3-4 then 0-1-2-5; Mem_Write_o high only in state 5 with Adr_Src_o = 1; Instr_Count_o = 2 after 9 cycles.
- beq with Zero_i = 1 → PC_Write_o = 1 in state 9; bne with Zero_i = 1 → PC_Write_o = 0; Funct3 = 100 → PC_Write_o = 0.
- Opcode 1111111 → DECODE returns to FETCH; Illegal_o = 1 and stays 1 through the next 3 legal instructions; Instr_Count_o is unchanged by the illegal opcode.
- COUNT_WIDTH = 4, 17 R-type instructions → Instr_Count_o = 1 (wrap).
- Assert reset in state 5 (mid-sw) → State_o = 0 and Mem_Write_o = 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch, decode, memory, ALU and
// branch steps; counts retired instructions and flags illegal opcodes.
module multicycle_control_unit #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             Opcode_i,
    input  logic [2:0]             Funct3_i,
    input  logic                   Zero_i,
    output logic                   PC_Write_o,
    output logic                   IR_Write_o,
    output logic                   Adr_Src_o,
    output logic                   Mem_Write_o,
    output logic                   Reg_Write_o,
    output logic [1:0]             ALU_Src_A_o,
    output logic [1:0]             ALU_Src_B_o,
    output logic [1:0]             ALU_Op_o,
    output logic [1:0]             Result_Src_o,
    output logic [3:0]             State_o,
    output logic                   Illegal_o,
    output logic [COUNT_WIDTH-1:0] Instr_Count_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   illegal_q, illegal_d;
    logic                   taken;

    always_comb begin
        taken = 1'b0;
        case (Funct3_i)
            3'b000:  taken = Zero_i;
            3'b001:  taken = ~Zero_i;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = S_FETCH;
        count_d   = count_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:
                state_d = (Opcode_i == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: state_d = S_MEM_WB;
            S_EXEC_R, S_EXEC_I, S_JAL:
                state_d = S_ALU_WB;
            // Final step of every legal instruction retires it
            S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH: begin
                state_d = S_FETCH;
                count_d = count_q + COUNT_WIDTH'(1);
            end
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        PC_Write_o   = 1'b0;
        IR_Write_o   = 1'b0;
        Adr_Src_o    = 1'b0;
        Mem_Write_o  = 1'b0;
        Reg_Write_o  = 1'b0;
        ALU_Src_A_o  = 2'b00;
        ALU_Src_B_o  = 2'b00;
        ALU_Op_o     = 2'b00;
        Result_Src_o = 2'b00;
        case (state_q)
            S_FETCH: begin
                IR_Write_o   = 1'b1;
                PC_Write_o   = 1'b1;
                ALU_Src_B_o  = 2'b10;
                Result_Src_o = 2'b10;
            end
            S_DECODE: begin
                ALU_Src_A_o = 2'b01;
                ALU_Src_B_o = 2'b01;
            end
            S_MEM_ADDR: begin
                ALU_Src_A_o = 2'b10;
                ALU_Src_B_o = 2'b01;
            end
            S_MEM_READ: Adr_Src_o = 1'b1;
            S_MEM_WB: begin
                Reg_Write_o  = 1'b1;
                Result_Src_o = 2'b01;
            end
            S_MEM_WRITE: begin
                Adr_Src_o   = 1'b1;
                Mem_Write_o = 1'b1;
            end
            S_EXEC_R: begin
                ALU_Src_A_o = 2'b10;
                ALU_Op_o    = 2'b10;
            end
            S_EXEC_I: begin
                ALU_Src_A_o = 2'b10;
                ALU_Src_B_o = 2'b01;
                ALU_Op_o    = 2'b10;
            end
            S_ALU_WB:   Reg_Write_o = 1'b1;
            S_BRANCH: begin
                ALU_Src_A_o = 2'b10;
                ALU_Op_o    = 2'b01;
                PC_Write_o  = taken;
            end
            S_JAL: begin
                ALU_Src_A_o = 2'b01;
                ALU_Src_B_o = 2'b10;
                PC_Write_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign State_o       = state_q;
    assign Illegal_o     = illegal_q;
    assign Instr_Count_o = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit against a
// per-instruction sequence model.
module tb_multicycle_control_unit;

    logic        clk;
    logic        reset;
    logic [6:0]  Opcode_i;
    logic [2:0]  Funct3_i;
    logic        Zero_i;
    logic        PC_Write_o, IR_Write_o, Adr_Src_o, Mem_Write_o, Reg_Write_o;
    logic [1:0]  ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Result_Src_o;
    logic [3:0]  State_o;
    logic        Illegal_o;
    logic [31:0] Instr_Count_o;

    logic        w_pc, w_ir, w_adr, w_mw, w_rw, w_ill;
    logic [1:0]  w_a, w_b, w_op, w_res;
    logic [3:0]  w_state;
    logic [3:0]  w_count;

    int checks;
    int errors;
    int unsigned exp_count;
    bit exp_illegal;

    multicycle_control_unit #(.COUNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .Opcode_i(Opcode_i), .Funct3_i(Funct3_i), .Zero_i(Zero_i),
        .PC_Write_o(PC_Write_o), .IR_Write_o(IR_Write_o),
        .Adr_Src_o(Adr_Src_o), .Mem_Write_o(Mem_Write_o),
        .Reg_Write_o(Reg_Write_o), .ALU_Src_A_o(ALU_Src_A_o),
        .ALU_Src_B_o(ALU_Src_B_o), .ALU_Op_o(ALU_Op_o),
        .Result_Src_o(Result_Src_o), .State_o(State_o),
        .Illegal_o(Illegal_o), .Instr_Count_o(Instr_Count_o)
    );

    multicycle_control_unit #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset),
        .Opcode_i(Opcode_i), .Funct3_i(Funct3_i), .Zero_i(Zero_i),
        .PC_Write_o(w_pc), .IR_Write_o(w_ir),
        .Adr_Src_o(w_adr), .Mem_Write_o(w_mw),
        .Reg_Write_o(w_rw), .ALU_Src_A_o(w_a),
        .ALU_Src_B_o(w_b), .ALU_Op_o(w_op),
        .Result_Src_o(w_res), .State_o(w_state),
        .Illegal_o(w_ill), .Instr_Count_o(w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011,
                          7'b0010011, 7'b1100011, 7'b1101111};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (State_o !== 4'd0 || Instr_Count_o !== 32'd0 || Illegal_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d count=%0d ill=%b want 0/0/0",
                     State_o, Instr_Count_o, Illegal_o);
        end
        checks++;
        if ({PC_Write_o, IR_Write_o, Mem_Write_o, Reg_Write_o} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_outputs: pc/ir/mw/rw=%b want 1100",
                     {PC_Write_o, IR_Write_o, Mem_Write_o, Reg_Write_o});
        end
        exp_count   = 0;
        exp_illegal = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    // Runs one instruction from FETCH back to FETCH, checking every cycle
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic z);
        int seq[$];
        bit taken;
        bit wb;
        taken = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
        case (op)
            7'b0000011: seq = '{0, 1, 2, 3, 4};
            7'b0100011: seq = '{0, 1, 2, 5};
            7'b0110011: seq = '{0, 1, 6, 8};
            7'b0010011: seq = '{0, 1, 7, 8};
            7'b1101111: seq = '{0, 1, 10, 8};
            7'b1100011: seq = '{0, 1, 9};
            default:    seq = '{0, 1};
        endcase
        wb = op inside {7'b0000011, 7'b0110011, 7'b0010011, 7'b1101111};
        Opcode_i = op;
        Funct3_i = f3;
        Zero_i   = z;
        for (int i = 0; i < seq.size(); i++) begin
            bit e_mw, e_rw, e_pc, e_adr;
            e_mw  = (op == 7'b0100011) && i == 3;
            e_adr = (op inside {7'b0000011, 7'b0100011}) && i == 3;
            e_rw  = wb && i == seq.size() - 1;
            e_pc  = (i == 0) || (op == 7'b1101111 && i == 2)
                 || (op == 7'b1100011 && i == 2 && taken);
            checks++;
            if (State_o !== 4'(seq[i])) begin
                errors++;
                $display("FAIL seq_state op=%b step=%0d: got %0d want %0d",
                         op, i, State_o, seq[i]);
            end
            checks++;
            if ({Mem_Write_o, Reg_Write_o, PC_Write_o, Adr_Src_o}
                !== {e_mw, e_rw, e_pc, e_adr}) begin
                errors++;
                $display("FAIL seq_ctrl op=%b f3=%b z=%b step=%0d: mw/rw/pc/adr=%b want %b",
                         op, f3, z, i,
                         {Mem_Write_o, Reg_Write_o, PC_Write_o, Adr_Src_o},
                         {e_mw, e_rw, e_pc, e_adr});
            end
            @(posedge clk);
            #1;
        end
        if (is_legal(op)) exp_count++;
        else exp_illegal = 1'b1;
        checks++;
        if (State_o !== 4'd0 || Instr_Count_o !== exp_count
            || w_count !== exp_count[3:0]) begin
            errors++;
            $display("FAIL retire op=%b: state=%0d count=%0d count4=%0d want 0/%0d/%0d",
                     op, State_o, Instr_Count_o, w_count, exp_count,
                     exp_count[3:0]);
        end
        checks++;
        if (Illegal_o !== exp_illegal) begin
            errors++;
            $display("FAIL illegal_flag op=%b: got %b want %b",
                     op, Illegal_o, exp_illegal);
        end
    endtask

    task automatic test_rtype_after_reset();
        test_reset();
        run_instr(7'b0110011, 3'b000, 1'b0);
    endtask

    task automatic test_datapath_selects();
        test_reset();
        Opcode_i = 7'b0110011;
        checks++;
        if ({ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Result_Src_o} !== 8'b00_10_00_10) begin
            errors++;
            $display("FAIL sel_fetch: got %b want 00100010",
                     {ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Result_Src_o});
        end
        @(posedge clk); #1;
        checks++;
        if ({ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o} !== 6'b01_01_00) begin
            errors++;
            $display("FAIL sel_decode: got %b want 010100",
                     {ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o});
        end
        @(posedge clk); #1;
        checks++;
        if ({ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o} !== 6'b10_00_10) begin
            errors++;
            $display("FAIL sel_exec_r: got %b want 100010",
                     {ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_count++;
    endtask

    task automatic test_lw_sw();
        test_reset();
        run_instr(7'b0000011, 3'b010, 1'b0);
        run_instr(7'b0100011, 3'b010, 1'b0);
    endtask

    task automatic test_branches();
        test_reset();
        run_instr(7'b1100011, 3'b000, 1'b1);
        run_instr(7'b1100011, 3'b000, 1'b0);
        run_instr(7'b1100011, 3'b001, 1'b1);
        run_instr(7'b1100011, 3'b001, 1'b0);
        run_instr(7'b1100011, 3'b100, 1'b1);
        run_instr(7'b1101111, 3'b000, 1'b0);
    endtask

    task automatic test_illegal();
        test_reset();
        run_instr(7'b1111111, 3'b000, 1'b0);
        run_instr(7'b0110011, 3'b000, 1'b0);
        run_instr(7'b0010011, 3'b000, 1'b0);
        run_instr(7'b1100011, 3'b001, 1'b0);
    endtask

    task automatic test_wrap();
        test_reset();
        for (int i = 0; i < 17; i++) run_instr(7'b0110011, 3'b000, 1'b0);
        checks++;
        if (w_count !== 4'd1 || Instr_Count_o !== 32'd17) begin
            errors++;
            $display("FAIL wrap: count4=%0d count32=%0d want 1/17",
                     w_count, Instr_Count_o);
        end
    endtask

    task automatic test_reset_mid_sw();
        test_reset();
        Opcode_i = 7'b0100011;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (State_o !== 4'd5 || Mem_Write_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_sw_pre: state=%0d mw=%b want 5/1",
                     State_o, Mem_Write_o);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (State_o !== 4'd0 || Mem_Write_o !== 1'b0 || Instr_Count_o !== 32'd0) begin
            errors++;
            $display("FAIL mid_sw_reset: state=%0d mw=%b count=%0d want 0/0/0",
                     State_o, Mem_Write_o, Instr_Count_o);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp_count   = 0;
        exp_illegal = 1'b0;
        run_instr(7'b0100011, 3'b010, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011,
                7'b0010011, 7'b1100011, 7'b1101111};
        test_reset();
        for (int n = 0; n < 80; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            int k;
            k = $urandom_range(0, 6);
            if (k < 6) begin
                op = ops[k];
            end else begin
                op = 7'b1111111;
                for (int t = 0; t < 16; t++) begin
                    logic [6:0] c;
                    c = 7'($urandom);
                    if (!is_legal(c)) begin
                        op = c;
                        break;
                    end
                end
            end
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
            run_instr(op, f3, 1'($urandom));
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_count   = 0;
        exp_illegal = 1'b0;
        reset       = 1'b0;
        Opcode_i    = 7'b0;
        Funct3_i    = 3'b0;
        Zero_i      = 1'b0;
        test_rtype_after_reset();
        test_datapath_selects();
        test_lw_sw();
        test_branches();
        test_illegal();
        test_wrap();
        test_reset_mid_sw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
